mawb_skid_stage: RTL and testbench

Parametrised MA→WB pipeline stage register. It replaces a plain clocked register with a two-entry skid buffer that uses a valid/ready handshake, so the stage can stall and flush. It carries a configurable number of data lanes plus control and destination-register fields. It sits between the memory-access stage (and DMem read data) and the write-back stage (register file, write-back data mux).

---
 rtl/mawb_skid_stage.sv | 152 +++++++++++++++
 tb/tb_mawb_skid_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mawb_skid_stage.sv
// rtl/mawb_skid_stage.sv - MA->WB pipeline stage built as a two-entry skid buffer
//
// Ports:
//   clkIn, resetIn      clock (rising edge), asynchronous active-low reset
//   flushIn             synchronous flush; kills held and incoming entries
//   validIn, readyOut   upstream handshake (readyOut is purely registered)
//   ctrSignalsIn, lanesIn, rdIn      incoming payload {ctrl, lanes, rd}
//   validOut, readyIn   downstream handshake
//   ctrSignalsOut       control field, gated to 0 on bubble cycles
//   lanesOut, rdOut     main-register payload, held when the stage drains
//   occOut              entries held (0..2)
//   stallCntOut         saturating count of back-pressure cycles
module mawb_skid_stage #(
    parameter int CTRL_W    = 3,
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4,
    parameter int RD_W      = 5,
    parameter int CNT_W     = 16
) (
    input  logic                        clkIn,
    input  logic                        resetIn,
    input  logic                        flushIn,
    input  logic                        validIn,
    output logic                        readyOut,
    input  logic [CTRL_W-1:0]           ctrSignalsIn,
    input  logic [NUM_LANES*DATA_W-1:0] lanesIn,
    input  logic [RD_W-1:0]             rdIn,
    output logic                        validOut,
    input  logic                        readyIn,
    output logic [CTRL_W-1:0]           ctrSignalsOut,
    output logic [NUM_LANES*DATA_W-1:0] lanesOut,
    output logic [RD_W-1:0]             rdOut,
    output logic [1:0]                  occOut,
    output logic [CNT_W-1:0]            stallCntOut
);

    localparam int LANES_W = NUM_LANES * DATA_W;
    localparam int PAY_W   = CTRL_W + LANES_W + RD_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PAY_W-1:0]   main_q;
    logic [PAY_W-1:0]   skid_q;
    logic [PAY_W-1:0]   in_pay;
    logic [CNT_W-1:0]   stall_cnt;

    logic               accept;
    logic               deliver;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid_in;

    assign in_pay  = {ctrSignalsIn, lanesIn, rdIn};
    assign accept  = validIn & readyOut;
    assign deliver = validOut & readyIn;

    // State register
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and payload-steering decode; flush overrides everything
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flushIn) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next   = ST_BUSY;
                        load_main_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && deliver) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next   = ST_FULL;
                        load_skid_in = 1'b1;
                    end else if (deliver) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        state_next     = ST_BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Payload registers. The skid copy is left stale after moving to main;
    // it is only ever read while the state says it is occupied.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flushIn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_pay;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_pay;
            end
        end
    end

    // Back-pressure counter: survives flush, cleared only by reset
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            stall_cnt <= '0;
        end else if (validOut && !readyIn && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        readyOut      = (state != ST_FULL);
        validOut      = (state != ST_EMPTY);
        occOut        = state;
        ctrSignalsOut = main_q[PAY_W-1 -: CTRL_W] & {CTRL_W{validOut}};
        lanesOut      = main_q[RD_W +: LANES_W];
        rdOut         = main_q[RD_W-1:0];
        stallCntOut   = stall_cnt;
    end

endmodule

// File: tb/tb_mawb_skid_stage.sv
// tb/tb_mawb_skid_stage.sv - scoreboard bench for mawb_skid_stage
module tb_mawb_skid_stage;

    localparam int CW = 3;
    localparam int DW = 32;
    localparam int NL = 4;
    localparam int RW = 5;
    localparam int LW = NL * DW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          valid_in;
    logic          ready_out;
    logic [CW-1:0] ctrl_in;
    logic [LW-1:0] lanes_in;
    logic [RW-1:0] rd_in;
    logic          valid_out;
    logic          ready_in;
    logic [CW-1:0] ctrl_out;
    logic [LW-1:0] lanes_out;
    logic [RW-1:0] rd_out;
    logic [1:0]    occ_out;
    logic [15:0]   stall_cnt;

    logic          s_ready_out;
    logic          s_valid_out;
    logic [CW-1:0] s_ctrl_out;
    logic [LW-1:0] s_lanes_out;
    logic [RW-1:0] s_rd_out;
    logic [1:0]    s_occ_out;
    logic [3:0]    s_stall_cnt;

    always #5 clk = ~clk;

    mawb_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .NUM_LANES(NL), .RD_W(RW), .CNT_W(16)) u_dut (
        .clkIn(clk), .resetIn(resetn), .flushIn(flush), .validIn(valid_in),
        .readyOut(ready_out), .ctrSignalsIn(ctrl_in), .lanesIn(lanes_in), .rdIn(rd_in),
        .validOut(valid_out), .readyIn(ready_in), .ctrSignalsOut(ctrl_out),
        .lanesOut(lanes_out), .rdOut(rd_out), .occOut(occ_out), .stallCntOut(stall_cnt)
    );

    mawb_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .NUM_LANES(NL), .RD_W(RW), .CNT_W(4)) u_sat (
        .clkIn(clk), .resetIn(resetn), .flushIn(flush), .validIn(valid_in),
        .readyOut(s_ready_out), .ctrSignalsIn(ctrl_in), .lanesIn(lanes_in), .rdIn(rd_in),
        .validOut(s_valid_out), .readyIn(ready_in), .ctrSignalsOut(s_ctrl_out),
        .lanesOut(s_lanes_out), .rdOut(s_rd_out), .occOut(s_occ_out), .stallCntOut(s_stall_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [LW-1:0] lanes;
        logic [RW-1:0] rd;
    } entry_t;

    entry_t q[$];
    entry_t last_main;
    int     m_cnt;
    int     n_tests;
    int     n_fail;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_lanes();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, LW'(valid_out), '0);
        check_eq({tag, "_ready"}, LW'(ready_out), LW'(1));
        check_eq({tag, "_occ"},   LW'(occ_out),   '0);
        check_eq({tag, "_ctrl"},  LW'(ctrl_out),  '0);
        check_eq({tag, "_lanes"}, lanes_out,      '0);
        check_eq({tag, "_rd"},    LW'(rd_out),    '0);
        check_eq({tag, "_cnt"},   LW'(stall_cnt), '0);
        check_eq({tag, "_scnt"},  LW'(s_stall_cnt), '0);
    endtask

    task automatic model_reset();
        q.delete();
        last_main = '0;
        m_cnt     = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        resetn   = 1'b0;
        valid_in = 1'b0;
        flush    = 1'b0;
        ready_in = 1'b1;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_reset_outputs("reset");
            @(negedge clk);
        end
        resetn = 1'b1;
    endtask

    // One clock cycle: drive at negedge, compare registered outputs against
    // the scoreboard, then advance the model by what the rising edge will do.
    task automatic cycle(input logic v, input logic rdy, input logic fl,
                         input logic [CW-1:0] c, input logic [LW-1:0] l, input logic [RW-1:0] r);
        entry_t e;
        int     occ;
        bit     acc;
        bit     del;
        @(negedge clk);
        valid_in = v;
        ready_in = rdy;
        flush    = fl;
        ctrl_in  = c;
        lanes_in = l;
        rd_in    = r;
        #1;
        occ = q.size();
        if (occ != 0) last_main = q[0];
        check_eq("ready", LW'(ready_out), LW'(occ != 2));
        check_eq("valid", LW'(valid_out), LW'(occ != 0));
        check_eq("occ",   LW'(occ_out),   LW'(occ));
        check_eq("ctrl",  LW'(ctrl_out),  (occ != 0) ? LW'(q[0].ctrl) : '0);
        check_eq("lanes", lanes_out,      last_main.lanes);
        check_eq("rd",    LW'(rd_out),    LW'(last_main.rd));
        check_eq("stall", LW'(stall_cnt), LW'(m_cnt[15:0]));
        check_eq("stall_sat", LW'(s_stall_cnt), LW'((m_cnt > 15) ? 15 : m_cnt));
        acc = v && (occ != 2);
        del = (occ != 0) && rdy;
        if (occ != 0 && !rdy) m_cnt++;
        if (del) void'(q.pop_front());
        if (fl) begin
            q.delete();
            last_main = '0;
        end else if (acc) begin
            e.ctrl  = c;
            e.lanes = l;
            e.rd    = r;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        ctrl_in  = '0;
        lanes_in = '0;
        rd_in    = '0;
        model_reset();

        // Reset then stream of rd 1..8
        do_reset(3);
        for (int i = 1; i <= 8; i++)
            cycle(1'b1, 1'b1, 1'b0, CW'($urandom()), rand_lanes(), RW'(i));
        idle(1'b1, 3);

        // Back-pressure: readyIn low for 4 cycles
        for (int i = 10; i < 12; i++)
            cycle(1'b1, 1'b1, 1'b0, CW'($urandom()), rand_lanes(), RW'(i));
        for (int i = 12; i < 16; i++)
            cycle(1'b1, 1'b0, 1'b0, CW'($urandom()), rand_lanes(), RW'(i));
        idle(1'b1, 4);

        // Flush while FULL with an entry presented
        cycle(1'b1, 1'b0, 1'b0, 3'b011, rand_lanes(), 5'd20);
        cycle(1'b1, 1'b0, 1'b0, 3'b110, rand_lanes(), 5'd21);
        cycle(1'b1, 1'b0, 1'b1, 3'b111, rand_lanes(), 5'd22);
        idle(1'b1, 3);

        // Bubble gating of the control field
        cycle(1'b1, 1'b1, 1'b0, 3'b101, {96'h0123_4567_89ab_cdef_0011_2233, 32'hDEADBEEF}, 5'd9);
        idle(1'b1, 3);

        // Counter saturation: 20 stalled cycles with a held entry
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 3'b001, rand_lanes(), 5'd3);
        idle(1'b0, 20);
        idle(1'b1, 3);

        // Asynchronous reset while FULL
        cycle(1'b1, 1'b0, 1'b0, 3'b010, rand_lanes(), 5'd4);
        cycle(1'b1, 1'b0, 1'b0, 3'b100, rand_lanes(), 5'd5);
        idle(1'b0, 1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        idle(1'b1, 2);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), CW'($urandom()), rand_lanes(), RW'($urandom()));
        idle(1'b1, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
